// File: rtl/decode_serialize_ctrl.sv
// Decode-stage serialization controller: gates how many decode slots may advance each cycle.
// Optional macro DECODE_SERIALIZE_PERF_EN adds a free-running serialization stall counter.
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 2
`endif

module decode_serialize_ctrl #(
  parameter int DECODE_WIDTH = `DECODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DECODE_WIDTH-1:0] slot_valid,
  input  logic [DECODE_WIDTH-1:0] slot_serialize,
  input  logic                    downstream_ready,
  input  logic                    pipeline_empty,
  input  logic                    flush,
  output logic [DECODE_WIDTH-1:0] accept_mask,
  output logic                    pop,
  output logic [1:0]              state,
  output logic                    idle,
  output logic [31:0]             stall_cycles
);

  typedef enum logic [1:0] {
    ST_NORMAL      = 2'd0,
    ST_DRAIN       = 2'd1,
    ST_WAIT_RETIRE = 2'd2,
    ST_ILLEGAL     = 2'd3
  } state_t;

  localparam logic [DECODE_WIDTH-1:0] HEAD_MASK = DECODE_WIDTH'(1);

  state_t                  state_r;
  state_t                  state_nxt;
  logic [1:0]              guard_r;
  logic [1:0]              guard_nxt;
  logic [1:0]              guard_inc;
  logic [DECODE_WIDTH-1:0] prefix;
  logic [DECODE_WIDTH-1:0] cons_ser;
  logic [DECODE_WIDTH-1:0] normal_mask;
  logic [DECODE_WIDTH-1:0] mask_nxt;

  // Contiguous valid prefix and the slots ahead of the first serializing one.
  always_comb begin
    logic run;
    logic seen;
    run         = 1'b1;
    seen        = 1'b0;
    prefix      = '0;
    cons_ser    = '0;
    normal_mask = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      run            = run & slot_valid[i];
      prefix[i]      = run;
      cons_ser[i]    = run & slot_serialize[i];
      seen           = seen | cons_ser[i];
      normal_mask[i] = run & ~seen;
    end
  end

  // Next-state, guard and accept decisions.
  always_comb begin
    state_nxt = state_r;
    guard_nxt = guard_r;
    mask_nxt  = '0;
    guard_inc = (guard_r == 2'd2) ? 2'd2 : guard_r + 2'd1;
    if (flush) begin
      state_nxt = ST_NORMAL;
      guard_nxt = 2'd0;
    end else begin
      case (state_r)
        ST_NORMAL: begin
          if (cons_ser[0]) begin
            if (pipeline_empty && downstream_ready) begin
              mask_nxt  = HEAD_MASK;
              state_nxt = ST_WAIT_RETIRE;
              guard_nxt = 2'd0;
            end else begin
              state_nxt = ST_DRAIN;
            end
          end else if (downstream_ready) begin
            mask_nxt = normal_mask;
          end else begin
            mask_nxt = '0;
          end
        end
        ST_DRAIN: begin
          if (!slot_valid[0]) begin
            state_nxt = ST_NORMAL;
          end else if (slot_serialize[0] && pipeline_empty && downstream_ready) begin
            mask_nxt  = HEAD_MASK;
            state_nxt = ST_WAIT_RETIRE;
            guard_nxt = 2'd0;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
        ST_WAIT_RETIRE: begin
          // The guard value after this cycle's increment decides the exit.
          guard_nxt = guard_inc;
          if ((guard_inc == 2'd2) && pipeline_empty) begin
            state_nxt = ST_NORMAL;
          end else begin
            state_nxt = ST_WAIT_RETIRE;
          end
        end
        default: begin
          state_nxt = ST_NORMAL;
          guard_nxt = 2'd0;
        end
      endcase
    end
  end

  // State and guard registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_NORMAL;
      guard_r <= 2'd0;
    end else begin
      state_r <= state_nxt;
      guard_r <= guard_nxt;
    end
  end

  assign accept_mask = rst ? mask_nxt : '0;
  assign pop         = |accept_mask;
  assign state       = state_r;
  assign idle        = (state_r == ST_NORMAL) && (slot_valid == '0);

`ifdef DECODE_SERIALIZE_PERF_EN
  logic [31:0] stall_cnt_r;

  // Counts every cycle spent in DRAIN or WAIT_RETIRE; flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == ST_DRAIN) || (state_r == ST_WAIT_RETIRE)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/decode_serialize_ctrl.md
DECODE_SERIALIZE_CTRL -- requirements
Module: decode_serialize_ctrl

Interface
REQ-001 SHALL take parameter DECODE_WIDTH, default `DECODE_WIDTH (2), the number of decode slots per cycle.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous, active-low (asserted at 0).
REQ-004 SHALL have port slot_valid, input, DECODE_WIDTH, per-slot valid from fetch_decode fifo head.
REQ-005 SHALL have port slot_serialize, input, DECODE_WIDTH, per-slot flag marking a serializing instruction (CSR, fence, mret, ecall, has_exception).
REQ-006 SHALL have port downstream_ready, input, 1, decode_rename fifo can take a full group this cycle.
REQ-007 SHALL have port pipeline_empty, input, 1, rename fifo and ROB both empty.
REQ-008 SHALL have port flush, input, 1, commit_feedback_pack.flush.
REQ-009 SHALL have port accept_mask, output, DECODE_WIDTH, slots decode may push and pop this cycle.
REQ-010 SHALL have port pop, output, 1, equal to OR of accept_mask.
REQ-011 SHALL have port state, output, 2, current FSM state (NORMAL=0, DRAIN=1, WAIT_RETIRE=2).
REQ-012 SHALL have port idle, output, 1, high when state==NORMAL and slot_valid==0.
REQ-013 SHALL have port stall_cycles, output, 32, serialization stall counter.

Function
REQ-014 Outputs accept_mask, pop, idle SHALL be combinational from current state and inputs (zero-latency); state, guard and counter SHALL be registered.
REQ-015 Only the contiguous valid prefix of slot_valid SHALL be considered; slots at or above the first 0 are ignored.
REQ-016 Let k = lowest considered slot with slot_serialize=1.
REQ-017 NORMAL, no k: accept_mask = considered prefix if downstream_ready, else 0; stay NORMAL.
REQ-018 NORMAL, k>0: accept slots 0..k-1 if downstream_ready, else 0; stay NORMAL.
REQ-019 NORMAL, k=0, pipeline_empty=1 and downstream_ready=1: accept slot 0 only; go WAIT_RETIRE; clear guard.
REQ-020 NORMAL, k=0, otherwise: accept none; go DRAIN.
REQ-021 DRAIN: accept none until slot_valid[0], slot_serialize[0], pipeline_empty and downstream_ready are all 1; then accept slot 0 only, go WAIT_RETIRE, clear guard.
REQ-022 DRAIN with slot_valid[0]=0: return to NORMAL, accept none.
REQ-023 WAIT_RETIRE: accept none; 2-bit guard increments, saturating at 2; return to NORMAL when guard==2 and pipeline_empty=1.
REQ-024 flush=1 in any state SHALL force accept_mask=0 that cycle and next state NORMAL, guard 0; flush dominates all other transitions.
REQ-025 State encoding 3 is illegal and SHALL recover to NORMAL on the next edge.

Reset
REQ-026 While rst=0: state=NORMAL, guard=0, stall_cycles=0, accept_mask=0, pop=0; idle follows REQ-012.
REQ-027 Reset mid-WAIT_RETIRE or mid-DRAIN SHALL abandon the sequence with no further accepts until released.

Configuration
REQ-028 With macro DECODE_SERIALIZE_PERF_EN defined: stall_cycles increments by 1 each cycle state is DRAIN or WAIT_RETIRE and wraps from 0xFFFFFFFF to 0; flush does not clear it.
REQ-029 Without DECODE_SERIALIZE_PERF_EN: stall_cycles SHALL be constant 0 and no counter register is synthesized; the port remains.

Verification
REQ-030 slot_valid=2'b11, serialize=0, ready=1 -> accept_mask=2'b11, pop=1, state stays 0.
REQ-031 slot_valid=2'b11, serialize=2'b10, ready=1 -> accept_mask=2'b01; next cycle head serializing, pipeline_empty=0 -> mask 0, state=1.
REQ-032 In DRAIN, raise pipeline_empty with ready=1 -> accept_mask=2'b01, state=2; hold pipeline_empty=1 -> state returns to 0 exactly 2 cycles later with mask 0 meanwhile.
REQ-033 In WAIT_RETIRE assert flush one cycle -> mask 0 that cycle, state=0 next cycle.
REQ-034 Macro on: DRAIN 3 cycles then WAIT_RETIRE 2 cycles -> stall_cycles=5; macro off -> stall_cycles=0 throughout.
REQ-035 Drive rst=0 asynchronously mid-DRAIN -> state=0, mask=0 immediately, before next clk edge.
